mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the 5-stage MIPS pipeline, placed between the EX/MEM register and the write-back selector. It accepts one instruction per handshake from EX and runs a req/ack transaction on the data-memory bus for loads and stores. Load data is aligned and sign- or zero-extended here. It registers ALU result, load data, incremented PC and the write-back select into the MEM/WB outputs, which feed the write-back 3:1 mux directly.

---
 rtl/mem_access_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Accepts one instruction per handshake from EX and runs a req/ack data-memory
// transaction for loads and stores. Loads are lane-aligned and sign- or
// zero-extended. Results are registered into the MEM/WB outputs.
module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX side
    input  logic        exValid,
    output logic        exReady,
    input  logic [31:0] exALUResult,
    input  logic [31:0] exStoreData,
    input  logic [31:0] exIncrPC,
    input  logic [1:0]  exMemToRegF,
    input  logic        exRegWrite,
    input  logic [4:0]  exWriteReg,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic [1:0]  exMemSize,
    input  logic        exMemSigned,
    // data-memory bus
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    // MEM/WB
    output logic        wbValid,
    output logic [31:0] wbALUResult,
    output logic [31:0] wbReadData,
    output logic [31:0] wbIncrPC,
    output logic [1:0]  wbMemToRegF,
    output logic [4:0]  wbWriteReg,
    output logic        wbRegWrite,
    output logic        memFault
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Counter value seen in the last request cycle before the access is abandoned.
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;

    // Latched instruction fields for the access in flight
    logic [31:0] r_alu;
    logic [31:0] r_incr_pc;
    logic [1:0]  r_m2r;
    logic        r_regwrite;
    logic [4:0]  r_wreg;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_cnt;

    // Registered bus drive
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    // MEM/WB registers
    logic        r_wb_valid;
    logic [31:0] r_wb_alu;
    logic [31:0] r_wb_rdata;
    logic [31:0] r_wb_incr_pc;
    logic [1:0]  r_wb_m2r;
    logic [4:0]  r_wb_wreg;
    logic        r_wb_regwrite;
    logic        r_wb_fault;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_be_next;
    logic [31:0] w_wdata_next;
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_accept  = exValid & exReady;
    assign w_is_mem  = exMemRead | exMemWrite;
    assign w_illegal = (exMemRead & exMemWrite) | (w_is_mem & w_misaligned);
    assign w_start   = w_accept & w_is_mem & ~w_illegal;
    assign w_timeout = (r_cnt == TO_LAST);

    // Size/alignment legality of the offered access (size 11 is never legal)
    always_comb begin
        w_misaligned = 1'b0;
        case (exMemSize)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = exALUResult[0];
            2'b10:   w_misaligned = |exALUResult[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    // Little-endian lane enables and replicated write data for the offered access
    always_comb begin
        w_be_next    = 4'b1111;
        w_wdata_next = exStoreData;
        case (exMemSize)
            2'b00: begin
                w_be_next    = 4'b0001 << exALUResult[1:0];
                w_wdata_next = {4{exStoreData[7:0]}};
            end
            2'b01: begin
                w_be_next    = exALUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata_next = {2{exStoreData[15:0]}};
            end
            default: begin
                w_be_next    = 4'b1111;
                w_wdata_next = exStoreData;
            end
        endcase
    end

    // Split the read bus into byte lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = memRData[8*gi +: 8];
    end

    assign w_byte = w_lane[r_alu[1:0]];
    assign w_half = r_alu[1] ? memRData[31:16] : memRData[15:0];

    // Extend the selected lane(s) of the read data to 32 bits
    always_comb begin
        w_load_ext = memRData;
        case (r_size)
            2'b00:   w_load_ext = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'b01:   w_load_ext = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_load_ext = memRData;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: leave IDLE on a legal memory op, return on ack or timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_ACCESS;
            S_ACCESS: if (memAck || w_timeout) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake is held off during reset and while the bus is busy
    always_comb begin
        exReady = rst_n & (r_state == S_IDLE);
        memReq  = (r_state == S_ACCESS);
    end

    // Datapath: capture accesses, run the timeout counter, load MEM/WB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu         <= '0;
            r_incr_pc     <= '0;
            r_m2r         <= '0;
            r_regwrite    <= 1'b0;
            r_wreg        <= '0;
            r_size        <= '0;
            r_signed      <= 1'b0;
            r_cnt         <= '0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= '0;
            r_mem_wdata   <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_alu      <= '0;
            r_wb_rdata    <= '0;
            r_wb_incr_pc  <= '0;
            r_wb_m2r      <= '0;
            r_wb_wreg     <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_fault    <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_alu       <= exALUResult;
                        r_incr_pc   <= exIncrPC;
                        r_m2r       <= exMemToRegF;
                        r_regwrite  <= exRegWrite;
                        r_wreg      <= exWriteReg;
                        r_size      <= exMemSize;
                        r_signed    <= exMemSigned;
                        r_cnt       <= '0;
                        r_mem_we    <= exMemWrite;
                        r_mem_be    <= w_be_next;
                        r_mem_wdata <= w_wdata_next;
                    end else if (w_accept) begin
                        // Non-memory or illegal op completes straight away
                        r_wb_valid    <= 1'b1;
                        r_wb_alu      <= exALUResult;
                        r_wb_rdata    <= '0;
                        r_wb_incr_pc  <= exIncrPC;
                        r_wb_m2r      <= exMemToRegF;
                        r_wb_wreg     <= exWriteReg;
                        r_wb_regwrite <= exRegWrite & ~w_illegal;
                        r_wb_fault    <= w_illegal;
                    end
                end
                S_ACCESS: begin
                    if (memAck || w_timeout) begin
                        r_wb_valid    <= 1'b1;
                        r_wb_alu      <= r_alu;
                        r_wb_incr_pc  <= r_incr_pc;
                        r_wb_m2r      <= r_m2r;
                        r_wb_wreg     <= r_wreg;
                        // An ack in the final request cycle still wins over the timeout
                        r_wb_rdata    <= (memAck && !r_mem_we) ? w_load_ext : 32'd0;
                        r_wb_regwrite <= memAck & r_regwrite;
                        r_wb_fault    <= ~memAck;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memWe       = r_mem_we;
    assign memAddr     = {r_alu[31:2], 2'b00};
    assign memByteEn   = r_mem_be;
    assign memWData    = r_mem_wdata;
    assign wbValid     = r_wb_valid;
    assign wbALUResult = r_wb_alu;
    assign wbReadData  = r_wb_rdata;
    assign wbIncrPC    = r_wb_incr_pc;
    assign wbMemToRegF = r_wb_m2r;
    assign wbWriteReg  = r_wb_wreg;
    assign wbRegWrite  = r_wb_regwrite;
    assign memFault    = r_wb_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases plus randomized traffic,
// checked through a scoreboard of expected MEM/WB completions.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        exValid;
    logic        exReady;
    logic [31:0] exALUResult;
    logic [31:0] exStoreData;
    logic [31:0] exIncrPC;
    logic [1:0]  exMemToRegF;
    logic        exRegWrite;
    logic [4:0]  exWriteReg;
    logic        exMemRead;
    logic        exMemWrite;
    logic [1:0]  exMemSize;
    logic        exMemSigned;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWData;
    logic        memAck;
    logic [31:0] memRData;
    logic        wbValid;
    logic [31:0] wbALUResult;
    logic [31:0] wbReadData;
    logic [31:0] wbIncrPC;
    logic [1:0]  wbMemToRegF;
    logic [4:0]  wbWriteReg;
    logic        wbRegWrite;
    logic        memFault;

    mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .exValid(exValid), .exReady(exReady),
        .exALUResult(exALUResult), .exStoreData(exStoreData), .exIncrPC(exIncrPC),
        .exMemToRegF(exMemToRegF), .exRegWrite(exRegWrite), .exWriteReg(exWriteReg),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exMemSize(exMemSize),
        .exMemSigned(exMemSigned),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn),
        .memWData(memWData), .memAck(memAck), .memRData(memRData),
        .wbValid(wbValid), .wbALUResult(wbALUResult), .wbReadData(wbReadData),
        .wbIncrPC(wbIncrPC), .wbMemToRegF(wbMemToRegF), .wbWriteReg(wbWriteReg),
        .wbRegWrite(wbRegWrite), .memFault(memFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] incr;
        logic [1:0]  m2r;
        logic [4:0]  wreg;
        logic        rw;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_illegal(input logic rd, input logic we,
                                         input logic [1:0] sz, input logic [31:0] a);
        if (rd && we) return 1'b1;
        if (!(rd || we)) return 1'b0;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sgn);
        int unsigned nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb = nbytes(sz);
        if (nb == 4) return rd;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = (rd >> (8 * (a % 4))) & mask;
        if (sgn && ((v >> (8 * nb - 1)) & 32'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        int unsigned nb;
        nb = nbytes(sz);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Issue one instruction (caller is at a negedge); delay = ack in req cycle N, 0 = never
    task automatic do_op(input logic [31:0] alu, input logic [31:0] sd,
                         input logic rd, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic rw, input logic [1:0] m2r,
                         input int delay, input logic [31:0] rdata);
        exp_t        e;
        bit          ill;
        bit          mem;
        int          w;
        int          k;
        logic [31:0] pc;
        logic [4:0]  wreg;
        pc   = $urandom;
        wreg = 5'($urandom);
        ill  = model_illegal(rd, we, sz, alu);
        mem  = (rd || we) && !ill;
        w = 0;
        while (!exReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!exReady) begin
            chk("ready_wait", {31'd0, exReady}, 32'd1);
            return;
        end
        e.alu  = alu;
        e.incr = pc;
        e.m2r  = m2r;
        e.wreg = wreg;
        if (ill) begin
            e.rdata = 0; e.rw = 1'b0; e.fault = 1'b1;
        end else if (!mem) begin
            e.rdata = 0; e.rw = rw; e.fault = 1'b0;
        end else if (delay == 0) begin
            e.rdata = 0; e.rw = 1'b0; e.fault = 1'b1;
        end else begin
            e.rdata = we ? 32'd0 : model_load(rdata, alu, sz, sgn);
            e.rw = rw; e.fault = 1'b0;
        end
        sb.push_back(e);
        exValid = 1'b1; exALUResult = alu; exStoreData = sd; exIncrPC = pc;
        exMemToRegF = m2r; exRegWrite = rw; exWriteReg = wreg; exMemRead = rd;
        exMemWrite = we; exMemSize = sz; exMemSigned = sgn;
        @(posedge clk);
        #1 exValid = 1'b0;
        @(negedge clk);
        if (!mem) begin
            chk("op_wb_latency", {31'd0, wbValid}, 32'd1);
            chk("op_no_req", {31'd0, memReq}, 32'd0);
            return;
        end
        chk("req_start", {31'd0, memReq}, 32'd1);
        chk("req_we", {31'd0, memWe}, {31'd0, we});
        chk("req_be", {28'd0, memByteEn}, {28'd0, model_be(alu, sz)});
        if (we) chk("req_wdata", memWData, model_wdata(sd, sz));
        k = 1;
        forever begin
            chk("req_addr", memAddr, alu & ~32'd3);
            if (delay == k) begin
                memAck = 1'b1; memRData = rdata;
                @(posedge clk);
                #1 memAck = 1'b0; memRData = $urandom;
                @(negedge clk);
                chk("ack_wb_valid", {31'd0, wbValid}, 32'd1);
                chk("ack_req_drop", {31'd0, memReq}, 32'd0);
                chk("ack_ready", {31'd0, exReady}, 32'd1);
                return;
            end
            @(negedge clk);
            if (!memReq) break;
            k++;
            if (k > 50) begin
                chk("req_bound", {31'd0, memReq}, 32'd0);
                return;
            end
        end
        chk("timeout_req_cycles", k, TO);
        chk("timeout_wb_valid", {31'd0, wbValid}, 32'd1);
        chk("timeout_ready", {31'd0, exReady}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; exValid = 1'b0; exALUResult = 0; exStoreData = 0; exIncrPC = 0;
        exMemToRegF = 0; exRegWrite = 0; exWriteReg = 0; exMemRead = 0; exMemWrite = 0;
        exMemSize = 0; exMemSigned = 0; memAck = 0; memRData = 0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (wbValid) begin
                            if (sb.size() == 0) begin
                                chk("unexpected_wb", {31'd0, wbValid}, 32'd0);
                            end else begin
                                e = sb.pop_front();
                                chk("wb_alu", wbALUResult, e.alu);
                                chk("wb_rdata", wbReadData, e.rdata);
                                chk("wb_incr", wbIncrPC, e.incr);
                                chk("wb_m2r", {30'd0, wbMemToRegF}, {30'd0, e.m2r});
                                chk("wb_wreg", {27'd0, wbWriteReg}, {27'd0, e.wreg});
                                chk("wb_regwrite", {31'd0, wbRegWrite}, {31'd0, e.rw});
                                chk("wb_fault", {31'd0, memFault}, {31'd0, e.fault});
                            end
                        end else begin
                            chk("idle_flags", {30'd0, wbRegWrite, memFault}, 32'd0);
                        end
                    end
                end
            end
            begin : driver
                // Power-on reset
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_ready", {31'd0, exReady}, 32'd0);
                    chk("rst_req", {31'd0, memReq}, 32'd0);
                    chk("rst_wb_valid", {31'd0, wbValid}, 32'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_ready", {31'd0, exReady}, 32'd1);
                chk("post_rst_wbrw", {31'd0, wbRegWrite}, 32'd0);

                // Reset while in ACCESS: aborted load must not complete
                exValid = 1'b1; exALUResult = 32'h0000_5000; exMemRead = 1'b1;
                exMemWrite = 1'b0; exMemSize = 2'd2; exRegWrite = 1'b1;
                @(posedge clk);
                #1 exValid = 1'b0;
                @(negedge clk);
                chk("rst_access_req", {31'd0, memReq}, 32'd1);
                rst_n = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_acc_req", {31'd0, memReq}, 32'd0);
                    chk("rst_acc_wb", {31'd0, wbValid}, 32'd0);
                    chk("rst_acc_ready", {31'd0, exReady}, 32'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_acc_release", {31'd0, exReady}, 32'd1);
                chk("rst_acc_req_after", {31'd0, memReq}, 32'd0);

                // ALU stream, with a stray ack while the bus is idle
                for (int i = 1; i <= 4; i++) begin
                    memAck = (i == 2); memRData = 32'hFFFF_FFFF;
                    do_op(32'(i), 0, 0, 0, 2'd2, 0, 1, 2'b01, 0, 0);
                end
                memAck = 1'b0;

                // Byte loads at 0x1003, signed then unsigned
                do_op(32'h1003, 0, 1, 0, 2'd0, 1, 1, 2'b00, 3, 32'h80FF_0000);
                do_op(32'h1003, 0, 1, 0, 2'd0, 0, 1, 2'b00, 3, 32'h80FF_0000);
                // Half store at 0x2002
                do_op(32'h2002, 32'h1234_ABCD, 0, 1, 2'd1, 0, 0, 2'b01, 2, 0);
                // Misaligned word load
                do_op(32'h3001, 0, 1, 0, 2'd2, 0, 1, 2'b00, 1, 0);
                // Timeout
                do_op(32'h4000, 0, 1, 0, 2'd2, 0, 1, 2'b00, 0, 0);

                // Randomized traffic
                for (int n = 0; n < 120; n++) begin
                    int unsigned kind;
                    logic rd, we;
                    logic [1:0] sz;
                    logic [31:0] a;
                    kind = $urandom_range(0, 9);
                    rd = (kind >= 3 && kind <= 5) || kind == 9;
                    we = (kind >= 6);
                    sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    a = $urandom;
                    if ($urandom_range(0, 3) != 0) begin
                        if (sz == 2'd1) a = a & ~32'd1;
                        if (sz == 2'd2) a = a & ~32'd3;
                    end
                    do_op(a, $urandom, rd, we, sz, 1'($urandom), 1'($urandom),
                          2'($urandom_range(0, 2)),
                          ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO)),
                          $urandom);
                end
                repeat (3) @(negedge clk);
                chk("sb_empty", sb.size(), 32'd0);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
